// File: rtl/approx_stats_pkg.sv
// approx_stats_pkg: shared state encoding, widths and error-distance helper for approx_err_stats.
package approx_stats_pkg;
  localparam int WIDTH = 16;
  localparam int CNT_W = 16;
  localparam int PW = 2 * WIDTH;
  localparam int SUM_W = PW + CNT_W;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [PW-1:0] ed;
    logic          over;
  } ed_t;
  function automatic ed_t abs_diff(input logic [PW-1:0] exact, input logic [PW-1:0] approx);
    ed_t r;
    r.over = approx > exact;
    r.ed = r.over ? approx - exact : exact - approx;
    return r;
  endfunction
endpackage

// File: rtl/approx_ed_stage.sv
// approx_ed_stage: two-stage pipe turning (x, y, p_approx) into error distance and over-estimate flag.
module approx_ed_stage #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  input  logic [WIDTH-1:0]   i_x,
  input  logic [WIDTH-1:0]   i_y,
  input  logic [2*WIDTH-1:0] i_p,
  output logic               o_valid,
  output logic               o_pend,
  output logic [2*WIDTH-1:0] o_ed,
  output logic               o_over
);
  import approx_stats_pkg::*;
  logic               r_v1;
  logic [WIDTH-1:0]   r_x, r_y;
  logic [2*WIDTH-1:0] r_p;
  ed_t                w_d;
  assign w_d = abs_diff((2*WIDTH)'(r_x) * (2*WIDTH)'(r_y), r_p);
  assign o_pend = r_v1 | o_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_x <= '0;
      r_y <= '0;
      r_p <= '0;
      o_valid <= 1'b0;
      o_ed <= '0;
      o_over <= 1'b0;
    end else begin
      r_v1 <= i_valid;
      if (i_valid) begin
        r_x <= i_x;
        r_y <= i_y;
        r_p <= i_p;
      end
      o_valid <= r_v1;
      if (r_v1) begin
        o_ed <= w_d.ed;
        o_over <= w_d.over;
      end
    end
  end
endmodule

// File: rtl/approx_err_stats.sv
// approx_err_stats: runs NSAMP (x, y, p_approx) triples through an exact check and
// accumulates error count, over-estimate count, max and sum of error distance.
module approx_err_stats #(
  parameter int WIDTH = 16,
  parameter int NSAMP = 50,
  parameter int CNT_W = 16,
  parameter int SUM_W = 2 * WIDTH + CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [2*WIDTH-1:0] p_approx,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   over_cnt,
  output logic [2*WIDTH-1:0] max_ed,
  output logic [SUM_W-1:0]   sum_ed
);
  import approx_stats_pkg::*;
  state_t             r_state;
  logic [CNT_W-1:0]   r_acc;
  logic               w_fire, w_last, w_v2, w_pend, w_over, w_clr;
  logic [2*WIDTH-1:0] w_ed;
  assign w_fire = in_valid && in_ready;
  assign w_last = w_fire && r_acc == CNT_W'(NSAMP - 1);
  assign w_clr = r_state == IDLE && start;
  approx_ed_stage #(.WIDTH(WIDTH)) u_stage (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_fire),
    .i_x     (x),
    .i_y     (y),
    .i_p     (p_approx),
    .o_valid (w_v2),
    .o_pend  (w_pend),
    .o_ed    (w_ed),
    .o_over  (w_over)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc <= '0;
      in_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state <= RUN;
          r_acc <= '0;
          in_ready <= 1'b1;
          busy <= 1'b1;
        end
        RUN: begin
          r_acc <= r_acc + CNT_W'(w_fire);
          if (w_last) begin
            r_state <= DRAIN;
            in_ready <= 1'b0;
          end
        end
        // empty pipe means the last sample has already been accumulated
        DRAIN: if (!w_pend) begin
          r_state <= DONE;
          done <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || w_clr) begin
      sample_cnt <= '0;
      err_cnt <= '0;
      over_cnt <= '0;
      max_ed <= '0;
      sum_ed <= '0;
    end else if (w_v2) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
      err_cnt <= err_cnt + CNT_W'(w_ed != '0);
      over_cnt <= over_cnt + CNT_W'(w_over);
      max_ed <= w_ed > max_ed ? w_ed : max_ed;
      sum_ed <= sum_ed + SUM_W'(w_ed);
    end
  end
endmodule

// File: tb/tb_approx_err_stats.sv
// tb_approx_err_stats: three instances (NSAMP 4, 3, 50) each checked every cycle against a
// sample-list reference model, plus hand-computed literal expectations.
module tb_approx_err_stats;
  typedef struct {
    int          c;
    logic [31:0] ed;
    bit          ov;
  } samp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st[3], iv[3], rdy[3], bsy[3], dn[3];
  logic [15:0] xa[3], ya[3], sc[3], ec[3], oc[3];
  logic [31:0] pa[3], mx[3];
  logic [47:0] sm[3];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int g, input bit s, input bit v, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] p);
    @(posedge clk);
    #1;
    st[g] = s;
    iv[g] = v;
    xa[g] = a;
    ya[g] = b;
    pa[g] = p;
  endtask

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int NS = g == 0 ? 4 : g == 1 ? 3 : 50;
    samp_t q[$];
    int    cyc = 0;
    int    n_acc = 0;
    int    last = -10;
    bit    active = 1'b0;
    approx_err_stats #(.NSAMP(NS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (st[g]),
      .in_valid   (iv[g]),
      .in_ready   (rdy[g]),
      .x          (xa[g]),
      .y          (ya[g]),
      .p_approx   (pa[g]),
      .busy       (bsy[g]),
      .done       (dn[g]),
      .sample_cnt (sc[g]),
      .err_cnt    (ec[g]),
      .over_cnt   (oc[g]),
      .max_ed     (mx[g]),
      .sum_ed     (sm[g])
    );
    // model: a run is the list of accepted samples, each counted two edges after acceptance
    initial forever begin
      bit          pdone, prdy;
      logic [31:0] e, p;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        active = 1'b0;
        n_acc = 0;
        q.delete();
      end else begin
        pdone = active && n_acc == NS && cyc == last + 3;
        prdy = active && n_acc < NS;
        cyc++;
        if (!active && st[g]) begin
          active = 1'b1;
          n_acc = 0;
          q.delete();
        end else if (prdy && iv[g]) begin
          e = 32'(xa[g]) * 32'(ya[g]);
          p = pa[g];
          q.push_back('{cyc, e > p ? e - p : p - e, p > e});
          n_acc++;
          last = cyc;
        end
        if (pdone) active = 1'b0;
      end
    end
    initial forever begin
      @(negedge clk);
      if (rst_n) begin
        logic [15:0] e_sc, e_ec, e_oc;
        logic [31:0] e_mx;
        logic [47:0] e_sm;
        e_sc = 0;
        e_ec = 0;
        e_oc = 0;
        e_mx = 0;
        e_sm = 0;
        foreach (q[i]) if (q[i].c <= cyc - 2) begin
          e_sc = e_sc + 16'd1;
          e_ec = e_ec + 16'(q[i].ed != 0);
          e_oc = e_oc + 16'(q[i].ov);
          e_mx = q[i].ed > e_mx ? q[i].ed : e_mx;
          e_sm = e_sm + 48'(q[i].ed);
        end
        chk($sformatf("u%0d.busy", g), 64'(bsy[g]), 64'(active));
        chk($sformatf("u%0d.in_ready", g), 64'(rdy[g]), 64'(active && n_acc < NS));
        chk($sformatf("u%0d.done", g), 64'(dn[g]), 64'(active && n_acc == NS && cyc == last + 3));
        chk($sformatf("u%0d.sample_cnt", g), 64'(sc[g]), 64'(e_sc));
        chk($sformatf("u%0d.err_cnt", g), 64'(ec[g]), 64'(e_ec));
        chk($sformatf("u%0d.over_cnt", g), 64'(oc[g]), 64'(e_oc));
        chk($sformatf("u%0d.max_ed", g), 64'(mx[g]), 64'(e_mx));
        chk($sformatf("u%0d.sum_ed", g), 64'(sm[g]), 64'(e_sm));
      end
    end
  end

  task automatic stats(input string nm, input int g, input int s, input int e, input int o,
                       input logic [31:0] m, input logic [47:0] su);
    chk({nm, ".sample_cnt"}, 64'(sc[g]), 64'(s));
    chk({nm, ".err_cnt"}, 64'(ec[g]), 64'(e));
    chk({nm, ".over_cnt"}, 64'(oc[g]), 64'(o));
    chk({nm, ".max_ed"}, 64'(mx[g]), 64'(m));
    chk({nm, ".sum_ed"}, 64'(sm[g]), 64'(su));
  endtask

  task automatic done_watch(input string nm, input int g, input int exp_at, input int exp_n);
    int at, nd;
    at = 0;
    nd = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (dn[g]) begin
        nd++;
        at = i;
      end
    end
    chk({nm, ".done_cnt"}, 64'(nd), 64'(exp_n));
    if (exp_n != 0) chk({nm, ".done_at"}, 64'(at), 64'(exp_at));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          nv;
    bit          v;
    logic [15:0] a, b;
    logic [31:0] e, p;
    void'($urandom(7));
    for (int g = 0; g < 3; g++) begin
      st[g] = 1'b1;
      iv[g] = 1'b1;
      xa[g] = 16'd3;
      ya[g] = 16'd3;
      pa[g] = 32'd1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst.busy", 64'(bsy[g]), 64'd0);
      chk("rst.in_ready", 64'(rdy[g]), 64'd0);
      chk("rst.done", 64'(dn[g]), 64'd0);
      stats("rst", g, 0, 0, 0, 0, 0);
    end
    for (int g = 0; g < 3; g++) begin
      st[g] = 1'b0;
      iv[g] = 1'b0;
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst.busy", 64'(bsy[0]), 64'd0);

    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 1, 1);
    drive(0, 0, 1, 255, 255, 32'd65025);
    drive(0, 0, 1, 65535, 65535, 32'd4294836225);
    drive(0, 0, 0, 0, 0, 0);
    done_watch("exact", 0, 4, 1);
    stats("exact", 0, 4, 0, 0, 0, 0);

    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 3, 5, 32'd14);
    drive(0, 0, 1, 100, 100, 32'd10010);
    drive(0, 0, 1, 65534, 65534, 32'd0);
    drive(0, 0, 1, 2, 2, 32'd4);
    drive(0, 0, 0, 0, 0, 0);
    done_watch("known", 0, 4, 1);
    stats("known", 0, 4, 3, 1, 32'd4294705156, 48'd4294705167);

    drive(1, 1, 0, 0, 0, 0);
    drive(1, 0, 1, 2, 3, 32'd6);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 0, 1, 4, 4, 32'd15);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 10, 10, 32'd101);
    drive(1, 0, 1, 9, 9, 32'd0);
    @(negedge clk);
    chk("bp.ready_low", 64'(rdy[1]), 64'd0);
    drive(1, 0, 0, 0, 0, 0);
    repeat (6) @(negedge clk);
    stats("bp", 1, 3, 2, 1, 32'd1, 48'd2);

    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 5, 5, 32'd20);
    drive(0, 0, 1, 6, 6, 32'd36);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst.busy", 64'(bsy[0]), 64'd0);
    stats("midrst", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    done_watch("midrst", 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 7, 7, 32'd49);
    drive(0, 0, 1, 8, 8, 32'd60);
    drive(0, 0, 1, 0, 5, 32'd3);
    drive(0, 0, 1, 65535, 1, 32'd65535);
    drive(0, 0, 0, 0, 0, 0);
    done_watch("rerun", 0, 4, 1);
    stats("rerun", 0, 4, 2, 1, 32'd4, 48'd7);

    drive(2, 1, 0, 0, 0, 0);
    nv = 0;
    while (nv < 53) begin
      v = ($urandom % 4) != 0;
      a = 16'($urandom % 65535);
      b = 16'($urandom % 65535);
      e = 32'(a) * 32'(b);
      case ($urandom % 4)
        0: p = e;
        1: p = e + ($urandom % 256);
        2: p = e >= 32'd300 ? e - ($urandom % 300) : e;
        default: p = e ^ ($urandom & 32'hFFFF);
      endcase
      drive(2, 0, v, a, b, p);
      if (v) nv++;
    end
    drive(2, 0, 0, 0, 0, 0);
    repeat (8) @(negedge clk);
    chk("rand.sample_cnt", 64'(sc[2]), 64'd50);
    chk("rand.busy", 64'(bsy[2]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
